// File: rtl/cluster_priority_encoder.sv
// -----------------------------------------------------------------------------
// cluster_priority_encoder
//
// Purpose:
//   Two-stage priority encoder over a segmented valid-pattern-flag vector, plus
//   a capture FSM that assembles one streaming result per pass into a frame
//   list of cluster addresses.  The upstream truncator removes the lowest set
//   bit each cycle, so the streaming results of passes 0..MXCLUSTERS-1 are the
//   first MXCLUSTERS set bits of the latched vector in ascending order.
//
// Ports:
//   clock        in   fabric clock, rising-edge logic
//   reset        in   asynchronous, active-high reset
//   pass_in      in   pass number of the vector in vpfs_in (0 = freshly latched)
//   vpfs_in      in   truncated valid-pattern-flag vector, MXSEGS*64 bits
//   enc_adr      out  streaming address of lowest set bit, all-ones if none
//   enc_vld      out  streaming valid for enc_adr
//   cluster_adr  out  frame cluster list, slot i at [i*ADRB +: ADRB]
//   cluster_vld  out  per-slot valid of the frame list
//   cluster_cnt  out  number of valid slots
//   overflow     out  frame held more set bits than there are slots
//   frame_valid  out  one-cycle strobe, frame outputs were updated
// -----------------------------------------------------------------------------
module cluster_priority_encoder #(
    parameter int MXSEGS     = 12,
    parameter int MXCLUSTERS = 8,
    parameter int ADRB       = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [2:0]                   pass_in,
    input  logic [MXSEGS*64-1:0]         vpfs_in,
    output logic [ADRB-1:0]              enc_adr,
    output logic                         enc_vld,
    output logic [MXCLUSTERS*ADRB-1:0]   cluster_adr,
    output logic [MXCLUSTERS-1:0]        cluster_vld,
    output logic [3:0]                   cluster_cnt,
    output logic                         overflow,
    output logic                         frame_valid
);

    // Upper address bits carry the segment number, lower 6 the bit index.
    localparam int              SEGB        = ADRB - 6;
    localparam logic [ADRB-1:0] INVALID_ADR = {ADRB{1'b1}};
    localparam logic [2:0]      LAST_PASS   = 3'(MXCLUSTERS - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Index of the lowest set bit of a 64-bit segment (0 when empty).
    function automatic logic [5:0] f_low_idx(input logic [63:0] v);
        logic [5:0] r;
        r = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            r = v[i] ? 6'(i) : r;
        end
        return r;
    endfunction

    // Two or more bits set: clearing the lowest set bit leaves something.
    function automatic logic f_is_multi(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

    // Number of set bits in the slot-valid vector.
    function automatic logic [3:0] f_popcount(input logic [MXCLUSTERS-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < MXCLUSTERS; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // Stage 1: per-segment summary
    // -------------------------------------------------------------------------
    logic [MXSEGS-1:0]      w_s1_any;
    logic [MXSEGS-1:0]      w_s1_multi;
    logic [MXSEGS-1:0][5:0] w_s1_idx;

    logic [MXSEGS-1:0]      r_s1_any;
    logic [MXSEGS-1:0]      r_s1_multi;
    logic [MXSEGS-1:0][5:0] r_s1_idx;
    logic [2:0]             r_s1_pass;
    logic                   r_s1_ok;

    // Summarise each 64-bit segment of the incoming vector.
    always_comb begin
        w_s1_any   = {MXSEGS{1'b0}};
        w_s1_multi = {MXSEGS{1'b0}};
        w_s1_idx   = {(MXSEGS*6){1'b0}};
        for (int s = 0; s < MXSEGS; s++) begin
            w_s1_any[s]   = |vpfs_in[s*64 +: 64];
            w_s1_multi[s] = f_is_multi(vpfs_in[s*64 +: 64]);
            w_s1_idx[s]   = f_low_idx(vpfs_in[s*64 +: 64]);
        end
    end

    // Stage-1 register; r_s1_ok marks the first real sample after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_any   <= {MXSEGS{1'b0}};
            r_s1_multi <= {MXSEGS{1'b0}};
            r_s1_idx   <= {(MXSEGS*6){1'b0}};
            r_s1_pass  <= 3'd0;
            r_s1_ok    <= 1'b0;
        end else begin
            r_s1_any   <= w_s1_any;
            r_s1_multi <= w_s1_multi;
            r_s1_idx   <= w_s1_idx;
            r_s1_pass  <= pass_in;
            r_s1_ok    <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: lowest active segment select
    // -------------------------------------------------------------------------
    logic            w_found;
    logic [SEGB-1:0] w_sel;
    logic [5:0]      w_sel_idx;
    logic            w_more;
    logic [ADRB-1:0] w_s2_adr_nxt;

    logic [ADRB-1:0] r_s2_adr;
    logic            r_s2_vld;
    logic            r_s2_more;
    logic [2:0]      r_s2_pass;
    logic            r_s2_ok;

    // Pick the lowest active segment; "more" collects the selected segment's
    // multi flag and any activity in segments above it.
    always_comb begin
        w_found   = 1'b0;
        w_sel     = {SEGB{1'b0}};
        w_sel_idx = 6'd0;
        w_more    = 1'b0;
        for (int s = 0; s < MXSEGS; s++) begin
            if (w_found) begin
                w_more = w_more | r_s1_any[s];
            end else if (r_s1_any[s]) begin
                w_found   = 1'b1;
                w_sel     = SEGB'(s);
                w_sel_idx = r_s1_idx[s];
                w_more    = r_s1_multi[s];
            end else begin
                w_more = w_more;
            end
        end
        w_s2_adr_nxt = w_found ? {w_sel, w_sel_idx} : INVALID_ADR;
    end

    // Stage-2 register; also the streaming outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s2_adr  <= INVALID_ADR;
            r_s2_vld  <= 1'b0;
            r_s2_more <= 1'b0;
            r_s2_pass <= 3'd0;
            r_s2_ok   <= 1'b0;
        end else begin
            r_s2_adr  <= w_s2_adr_nxt;
            r_s2_vld  <= w_found;
            r_s2_more <= w_more;
            r_s2_pass <= r_s1_pass;
            r_s2_ok   <= r_s1_ok;
        end
    end

    assign enc_adr = r_s2_adr;
    assign enc_vld = r_s2_vld;

    // -------------------------------------------------------------------------
    // Capture FSM and slot storage
    // -------------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2:0]              r_last_pass;
    logic [2:0]              w_pass_nxt;
    logic                    w_clear;
    logic                    w_wr_en;
    logic                    w_load;

    logic [ADRB-1:0]         r_slot_adr [MXCLUSTERS];
    logic [MXCLUSTERS-1:0]   r_slot_vld;

    // Next-state logic: pass 0 (re)starts a frame, consecutive passes fill
    // slots, the last pass completes the frame, anything else aborts.
    always_comb begin
        w_state_nxt = r_state;
        w_pass_nxt  = r_last_pass;
        w_clear     = 1'b0;
        w_wr_en     = 1'b0;
        w_load      = 1'b0;
        if (r_s2_ok) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_s2_pass == 3'd0) begin
                        w_state_nxt = ST_CAPTURE;
                        w_pass_nxt  = 3'd0;
                        w_clear     = 1'b1;
                        w_wr_en     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (r_s2_pass == 3'd0) begin
                        // Early re-latch: drop the partial frame, start over.
                        w_state_nxt = ST_CAPTURE;
                        w_pass_nxt  = 3'd0;
                        w_clear     = 1'b1;
                        w_wr_en     = 1'b1;
                    end else if (r_s2_pass == (r_last_pass + 3'd1)) begin
                        w_pass_nxt = r_s2_pass;
                        w_wr_en    = 1'b1;
                        if (r_s2_pass == LAST_PASS) begin
                            w_load      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_CAPTURE;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State register and slot writes (clear happens before the slot-0 write).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last_pass <= 3'd0;
            r_slot_vld  <= {MXCLUSTERS{1'b0}};
            for (int i = 0; i < MXCLUSTERS; i++) begin
                r_slot_adr[i] <= INVALID_ADR;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_last_pass <= w_pass_nxt;
            if (w_clear) begin
                r_slot_vld <= {MXCLUSTERS{1'b0}};
                for (int i = 0; i < MXCLUSTERS; i++) begin
                    r_slot_adr[i] <= INVALID_ADR;
                end
            end
            if (w_wr_en) begin
                r_slot_adr[r_s2_pass] <= r_s2_adr;
                r_slot_vld[r_s2_pass] <= r_s2_vld;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame outputs
    // -------------------------------------------------------------------------
    logic [MXCLUSTERS*ADRB-1:0] w_frame_adr;
    logic [MXCLUSTERS-1:0]      w_frame_vld;

    // Slot contents with the result being written this cycle merged in, so
    // the load on the last pass already includes that pass.
    always_comb begin
        w_frame_adr = {MXCLUSTERS{INVALID_ADR}};
        w_frame_vld = {MXCLUSTERS{1'b0}};
        for (int i = 0; i < MXCLUSTERS; i++) begin
            if (w_wr_en && (r_s2_pass == 3'(i))) begin
                w_frame_adr[i*ADRB +: ADRB] = r_s2_adr;
                w_frame_vld[i]              = r_s2_vld;
            end else begin
                w_frame_adr[i*ADRB +: ADRB] = r_slot_adr[i];
                w_frame_vld[i]              = r_slot_vld[i];
            end
        end
    end

    logic [MXCLUSTERS*ADRB-1:0] r_cluster_adr;
    logic [MXCLUSTERS-1:0]      r_cluster_vld;
    logic [3:0]                 r_cluster_cnt;
    logic                       r_overflow;
    logic                       r_frame_valid;

    // Frame output registers: load on completion, otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cluster_adr <= {MXCLUSTERS{INVALID_ADR}};
            r_cluster_vld <= {MXCLUSTERS{1'b0}};
            r_cluster_cnt <= 4'd0;
            r_overflow    <= 1'b0;
            r_frame_valid <= 1'b0;
        end else if (w_load) begin
            r_cluster_adr <= w_frame_adr;
            r_cluster_vld <= w_frame_vld;
            r_cluster_cnt <= f_popcount(w_frame_vld);
            r_overflow    <= r_s2_more;
            r_frame_valid <= 1'b1;
        end else begin
            r_frame_valid <= 1'b0;
        end
    end

    assign cluster_adr = r_cluster_adr;
    assign cluster_vld = r_cluster_vld;
    assign cluster_cnt = r_cluster_cnt;
    assign overflow    = r_overflow;
    assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_cluster_priority_encoder.sv
// -----------------------------------------------------------------------------
// tb_cluster_priority_encoder
//
// Directed bench for cluster_priority_encoder.  A small truncator model turns a
// vector into the pass 0..7 stimulus stream (lowest set bit removed per pass);
// each test task queues stimulus, plays it, and compares the logged streaming
// results and the frame outputs against hand-computed values.
//
// Timing reference: with passes 0..7 driven on ticks 1..8, the pass-j
// streaming result is logged on tick j+2 and frame_valid on tick 10.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cluster_priority_encoder;

    localparam int MXSEGS     = 12;
    localparam int MXCLUSTERS = 8;
    localparam int ADRB       = 10;
    localparam int VW         = MXSEGS * 64;

    logic                       clock;
    logic                       reset;
    logic [2:0]                 pass_in;
    logic [VW-1:0]              vpfs_in;
    logic [ADRB-1:0]            enc_adr;
    logic                       enc_vld;
    logic [MXCLUSTERS*ADRB-1:0] cluster_adr;
    logic [MXCLUSTERS-1:0]      cluster_vld;
    logic [3:0]                 cluster_cnt;
    logic                       overflow;
    logic                       frame_valid;

    cluster_priority_encoder #(
        .MXSEGS(MXSEGS), .MXCLUSTERS(MXCLUSTERS), .ADRB(ADRB)
    ) dut (
        .clock(clock), .reset(reset), .pass_in(pass_in), .vpfs_in(vpfs_in),
        .enc_adr(enc_adr), .enc_vld(enc_vld), .cluster_adr(cluster_adr),
        .cluster_vld(cluster_vld), .cluster_cnt(cluster_cnt),
        .overflow(overflow), .frame_valid(frame_valid)
    );

    initial clock = 1'b0;
    always #3.125 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0]      q_pass [$];
    logic [VW-1:0]   q_vec  [$];
    logic [ADRB-1:0] enc_log     [64];
    logic            enc_vld_log [64];
    logic            fv_log      [64];
    int              n_ticks;

    localparam logic [ADRB-1:0] INV = 10'h3FF;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Truncator model: pass p carries the vector with its p lowest bits removed.
    task automatic push_frame(input logic [VW-1:0] v, input int npass);
        logic [VW-1:0] t;
        t = v;
        for (int p = 0; p < npass; p++) begin
            q_pass.push_back(3'(p));
            q_vec.push_back(t);
            t = t & (t - {{(VW-1){1'b0}}, 1'b1});
        end
    endtask

    task automatic push_raw(input logic [2:0] p, input logic [VW-1:0] v);
        q_pass.push_back(p);
        q_vec.push_back(v);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_raw(3'd7, {VW{1'b0}});
    endtask

    // Drive the queued stimulus one cycle per entry, logging outputs per tick.
    task automatic play();
        n_ticks = 0;
        for (int i = 0; i < 64; i++) begin
            enc_log[i] = INV; enc_vld_log[i] = 1'b0; fv_log[i] = 1'b0;
        end
        while (q_pass.size() > 0 && n_ticks < 63) begin
            pass_in = q_pass.pop_front();
            vpfs_in = q_vec.pop_front();
            tick();
            n_ticks++;
            enc_log[n_ticks]     = enc_adr;
            enc_vld_log[n_ticks] = enc_vld;
            fv_log[n_ticks]      = frame_valid;
        end
    endtask

    function automatic int fv_count();
        int c;
        c = 0;
        for (int i = 1; i <= n_ticks; i++) c += (fv_log[i] === 1'b1) ? 1 : 0;
        return c;
    endfunction

    function automatic int fv_first();
        int f;
        f = -1;
        for (int i = n_ticks; i >= 1; i--) f = (fv_log[i] === 1'b1) ? i : f;
        return f;
    endfunction

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        n_cmp++; if (enc_adr !== INV) begin n_bad++; $display("FAIL rst_enc_adr got=%h exp=%h", enc_adr, INV); end
        n_cmp++; if (enc_vld !== 1'b0) begin n_bad++; $display("FAIL rst_enc_vld got=%b exp=0", enc_vld); end
        n_cmp++; if (cluster_adr !== {8{INV}}) begin n_bad++; $display("FAIL rst_cluster_adr got=%h exp=%h", cluster_adr, {8{INV}}); end
        n_cmp++; if (cluster_vld !== 8'h00) begin n_bad++; $display("FAIL rst_cluster_vld got=%b exp=0", cluster_vld); end
        n_cmp++; if (cluster_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_cluster_cnt got=%0d exp=0", cluster_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
        n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL rst_frame_valid got=%b exp=0", frame_valid); end
        tick(); tick();
        reset = 1'b0;
        push_idle(6);
        play();
        n_cmp++; if (fv_count() !== 0) begin n_bad++; $display("FAIL rst_no_fv got=%0d exp=0", fv_count()); end
    endtask

    task automatic test_sparse();
        logic [VW-1:0] v;
        v = {VW{1'b0}}; v[5] = 1'b1; v[64] = 1'b1; v[700] = 1'b1;
        push_frame(v, 8); push_idle(4); play();
        n_cmp++; if (enc_log[2] !== 10'd5) begin n_bad++; $display("FAIL sparse_enc0 got=%0d exp=5", enc_log[2]); end
        n_cmp++; if (enc_log[3] !== 10'd64) begin n_bad++; $display("FAIL sparse_enc1 got=%0d exp=64", enc_log[3]); end
        n_cmp++; if (enc_log[4] !== 10'd700) begin n_bad++; $display("FAIL sparse_enc2 got=%0d exp=700", enc_log[4]); end
        n_cmp++; if (enc_vld_log[2] !== 1'b1) begin n_bad++; $display("FAIL sparse_vld0 got=%b exp=1", enc_vld_log[2]); end
        for (int t = 5; t <= 9; t++) begin
            n_cmp++; if (enc_log[t] !== INV || enc_vld_log[t] !== 1'b0) begin n_bad++; $display("FAIL sparse_enc_empty tick=%0d got=%h/%b exp=3ff/0", t, enc_log[t], enc_vld_log[t]); end
        end
        n_cmp++; if (fv_count() !== 1 || fv_first() !== 10) begin n_bad++; $display("FAIL sparse_fv got=%0d@%0d exp=1@10", fv_count(), fv_first()); end
        n_cmp++; if (cluster_adr !== {{5{INV}}, 10'd700, 10'd64, 10'd5}) begin n_bad++; $display("FAIL sparse_adr got=%h", cluster_adr); end
        n_cmp++; if (cluster_vld !== 8'b00000111) begin n_bad++; $display("FAIL sparse_vld got=%b exp=00000111", cluster_vld); end
        n_cmp++; if (cluster_cnt !== 4'd3) begin n_bad++; $display("FAIL sparse_cnt got=%0d exp=3", cluster_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sparse_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_overflow();
        logic [VW-1:0] v;
        v = {VW{1'b0}}; v[9:0] = 10'h3FF;
        push_frame(v, 8); push_idle(4); play();
        for (int j = 0; j < 8; j++) begin
            n_cmp++; if (enc_log[j+2] !== 10'(j)) begin n_bad++; $display("FAIL ovf_enc pass=%0d got=%0d exp=%0d", j, enc_log[j+2], j); end
        end
        n_cmp++; if (cluster_adr !== {10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1, 10'd0}) begin n_bad++; $display("FAIL ovf_adr got=%h", cluster_adr); end
        n_cmp++; if (cluster_cnt !== 4'd8 || cluster_vld !== 8'hFF) begin n_bad++; $display("FAIL ovf_cnt got=%0d/%b exp=8/11111111", cluster_cnt, cluster_vld); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    endtask

    task automatic test_exact8();
        logic [VW-1:0] v;
        v = {VW{1'b0}}; v[7:0] = 8'hFF;
        push_frame(v, 8); push_idle(4); play();
        n_cmp++; if (cluster_cnt !== 4'd8) begin n_bad++; $display("FAIL exact8_cnt got=%0d exp=8", cluster_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL exact8_ovf got=%b exp=0", overflow); end
        n_cmp++; if (fv_count() !== 1 || fv_first() !== 10) begin n_bad++; $display("FAIL exact8_fv got=%0d@%0d exp=1@10", fv_count(), fv_first()); end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] v;
        v = {VW{1'b0}}; v[3] = 1'b1; v[40] = 1'b1; v[90] = 1'b1; v[91] = 1'b1; v[500] = 1'b1;
        push_frame(v, 4); play();
        pass_in = 3'd4; vpfs_in = {VW{1'b0}}; vpfs_in[500] = 1'b1;
        reset = 1'b1;
        #1;
        n_cmp++; if (cluster_cnt !== 4'd0 || cluster_vld !== 8'h00) begin n_bad++; $display("FAIL rmid_cnt got=%0d/%b exp=0/0", cluster_cnt, cluster_vld); end
        n_cmp++; if (cluster_adr !== {8{INV}}) begin n_bad++; $display("FAIL rmid_adr got=%h", cluster_adr); end
        n_cmp++; if (overflow !== 1'b0 || frame_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_flags got=%b/%b exp=0/0", overflow, frame_valid); end
        n_cmp++; if (enc_adr !== INV || enc_vld !== 1'b0) begin n_bad++; $display("FAIL rmid_enc got=%h/%b exp=3ff/0", enc_adr, enc_vld); end
        tick(); tick();
        reset = 1'b0;
        push_idle(6); play();
        n_cmp++; if (fv_count() !== 0) begin n_bad++; $display("FAIL rmid_spurious_fv got=%0d exp=0", fv_count()); end
        v = {VW{1'b0}}; v[100] = 1'b1; v[200] = 1'b1;
        push_frame(v, 8); push_idle(4); play();
        n_cmp++; if (fv_count() !== 1 || fv_first() !== 10) begin n_bad++; $display("FAIL rmid_next_fv got=%0d@%0d exp=1@10", fv_count(), fv_first()); end
        n_cmp++; if (cluster_adr !== {{6{INV}}, 10'd200, 10'd100}) begin n_bad++; $display("FAIL rmid_next_adr got=%h", cluster_adr); end
        n_cmp++; if (cluster_cnt !== 4'd2 || cluster_vld !== 8'b00000011) begin n_bad++; $display("FAIL rmid_next_cnt got=%0d/%b exp=2/00000011", cluster_cnt, cluster_vld); end
    endtask

    task automatic test_zero();
        push_frame({VW{1'b0}}, 8); push_idle(4); play();
        n_cmp++; if (fv_count() !== 1 || fv_first() !== 10) begin n_bad++; $display("FAIL zero_fv got=%0d@%0d exp=1@10", fv_count(), fv_first()); end
        n_cmp++; if (cluster_adr !== {8{INV}}) begin n_bad++; $display("FAIL zero_adr got=%h", cluster_adr); end
        n_cmp++; if (cluster_cnt !== 4'd0 || cluster_vld !== 8'h00) begin n_bad++; $display("FAIL zero_cnt got=%0d/%b exp=0/0", cluster_cnt, cluster_vld); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL zero_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_single_top();
        logic [VW-1:0] v;
        v = {VW{1'b0}}; v[767] = 1'b1;
        push_frame(v, 8); push_idle(4); play();
        n_cmp++; if (enc_log[2] !== 10'd767 || enc_vld_log[2] !== 1'b1) begin n_bad++; $display("FAIL top_enc got=%0d/%b exp=767/1", enc_log[2], enc_vld_log[2]); end
        n_cmp++; if (cluster_adr !== {{7{INV}}, 10'd767}) begin n_bad++; $display("FAIL top_adr got=%h", cluster_adr); end
        n_cmp++; if (cluster_cnt !== 4'd1 || cluster_vld !== 8'b00000001) begin n_bad++; $display("FAIL top_cnt got=%0d/%b exp=1/00000001", cluster_cnt, cluster_vld); end
        for (int i = 0; i < 14; i++) push_raw(3'd0, v);
        play();
        n_cmp++; if (fv_count() !== 0) begin n_bad++; $display("FAIL frozen_fv got=%0d exp=0", fv_count()); end
        n_cmp++; if (enc_log[14] !== 10'd767) begin n_bad++; $display("FAIL frozen_enc got=%0d exp=767", enc_log[14]); end
        n_cmp++; if (cluster_cnt !== 4'd1) begin n_bad++; $display("FAIL frozen_hold got=%0d exp=1", cluster_cnt); end
    endtask

    task automatic test_early_latch();
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        a = {VW{1'b0}}; a[10] = 1'b1; a[20] = 1'b1; a[30] = 1'b1; a[40] = 1'b1; a[50] = 1'b1; a[60] = 1'b1; a[70] = 1'b1;
        b = {VW{1'b0}}; b[1] = 1'b1; b[2] = 1'b1;
        push_frame(a, 5); push_frame(b, 8); push_idle(4); play();
        n_cmp++; if (fv_count() !== 1 || fv_first() !== 15) begin n_bad++; $display("FAIL early_fv got=%0d@%0d exp=1@15", fv_count(), fv_first()); end
        n_cmp++; if (cluster_adr !== {{6{INV}}, 10'd2, 10'd1}) begin n_bad++; $display("FAIL early_adr got=%h", cluster_adr); end
        n_cmp++; if (cluster_cnt !== 4'd2 || cluster_vld !== 8'b00000011) begin n_bad++; $display("FAIL early_cnt got=%0d/%b exp=2/00000011", cluster_cnt, cluster_vld); end
    endtask

    task automatic test_abort();
        logic [VW-1:0] v;
        v = {VW{1'b0}}; v[3] = 1'b1; v[9] = 1'b1;
        push_frame(v, 3);
        for (int p = 4; p < 8; p++) push_raw(3'(p), {VW{1'b0}});
        push_idle(4); play();
        n_cmp++; if (fv_count() !== 0) begin n_bad++; $display("FAIL abort_fv got=%0d exp=0", fv_count()); end
        n_cmp++; if (cluster_adr !== {{6{INV}}, 10'd2, 10'd1}) begin n_bad++; $display("FAIL abort_hold_adr got=%h", cluster_adr); end
        n_cmp++; if (cluster_cnt !== 4'd2) begin n_bad++; $display("FAIL abort_hold_cnt got=%0d exp=2", cluster_cnt); end
    endtask

    initial begin
        reset   = 1'b0;
        pass_in = 3'd7;
        vpfs_in = {VW{1'b0}};
        #1;
        reset = 1'b1;
        #1;
        test_reset();
        test_sparse();
        test_overflow();
        test_reset_mid();
        test_zero();
        test_single_top();
        test_exact8();
        test_early_latch();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cluster_priority_encoder.md
CLUSTER_PRIORITY_ENCODER -- requirements
Module: cluster_priority_encoder

Interface
REQ-001 Parameter MXSEGS, default 12, number of 64-bit segments in the input vector.
REQ-002 Parameter MXCLUSTERS, default 8, number of cluster slots per frame (equal to passes per frame).
REQ-003 Parameter ADRB, default 10, address width; 10'h3FF is the invalid-slot sentinel.
REQ-004 clock  input  1  160 MHz fabric clock; all logic is on its rising edge.
REQ-005 reset  input  1  Asynchronous, active-high reset.
REQ-006 pass_in  input  3  Pass number from the cluster truncator; 0 marks the first cycle of a freshly latched vector.
REQ-007 vpfs_in  input  768  Truncated valid-pattern-flag vector; its lowest set bit is removed by the truncator each cycle.
REQ-008 enc_adr  output  ADRB  Streaming address of the lowest set bit, or 10'h3FF.
REQ-009 enc_vld  output  1  Streaming valid for enc_adr.
REQ-010 cluster_adr  output  MXCLUSTERS*ADRB  Frame cluster list; slot i occupies bits [i*ADRB +: ADRB].
REQ-011 cluster_vld  output  MXCLUSTERS  Per-slot valid for the frame list.
REQ-012 cluster_cnt  output  4  Number of valid slots, 0..8.
REQ-013 overflow  output  1  Frame contained more than MXCLUSTERS set bits.
REQ-014 frame_valid  output  1  One-cycle strobe; the frame outputs updated this cycle.

Function
REQ-015 Stage 1 shall register, per segment, an "any" flag, a "multi" flag (two or more bits set), and the 6-bit index of the lowest set bit, taken from the vpfs_in and pass_in present in cycle N.
REQ-016 Stage 2 shall select the lowest-numbered active segment and register enc_adr = seg*64 + idx with enc_vld = 1, visible in cycle N+2.
REQ-017 If no bit is set, stage 2 shall output enc_adr = 10'h3FF and enc_vld = 0.
REQ-018 Stage 2 shall register a "more" flag: the selected segment's multi flag OR any higher segment's any flag.
REQ-019 pass_in shall be pipelined alongside the data, so every stage-2 result carries the pass of its source vector.
REQ-020 Capture FSM states: IDLE, CAPTURE.
REQ-021 IDLE -> CAPTURE when the stage-2 pass is 0: clear all slots to 10'h3FF/invalid, then write the pass-0 result into slot 0.
REQ-022 In CAPTURE, a stage-2 result with pass p (1..7) shall be written into slot p.
REQ-023 In CAPTURE, a stage-2 pass of 0 shall discard the partial frame, raise no frame_valid, and restart capture at slot 0.
REQ-024 In CAPTURE, a pass that is not the previous pass +1 (other than 0) shall abort to IDLE with no frame_valid.
REQ-025 On the pass-7 result (cycle N+2), the registers cluster_adr, cluster_vld and cluster_cnt shall be loaded from the slots including the pass-7 result.
REQ-026 With the same load, overflow shall take the pass-7 "more" flag, frame_valid shall be 1 in cycle N+3, and the FSM shall return to IDLE.
REQ-027 Between frame loads, the frame outputs shall hold their last values.
REQ-028 cluster_cnt shall equal the popcount of the loaded cluster_vld.
REQ-029 Slot addresses shall be strictly increasing across valid slots.

Reset
REQ-030 Reset shall asynchronously clear all pipeline registers, slots and outputs.
REQ-031 During reset, all addresses shall be 10'h3FF, all valids 0, cluster_cnt 0, overflow 0, frame_valid 0, and the FSM in IDLE.
REQ-032 After reset release, no frame_valid shall occur until a complete pass 0..7 sequence has been captured.

Verification
REQ-033 Vector with bits 5, 64 and 700 set, truncator-driven passes 0..7 -> enc_adr sequence 5, 64, 700, 3FF...; cluster_cnt 3; cluster_vld 8'b00000111; overflow 0.
REQ-034 Vector with bits 0..9 set -> slots hold 0..7; cluster_cnt 8; overflow 1.
REQ-035 All-zero vector -> all slots 3FF; cluster_cnt 0; overflow 0; frame_valid still pulses once, 3 cycles after pass 7.
REQ-036 Only bit 767 set -> slot 0 = 767; cluster_cnt 1; only bit 767 set with pass_in frozen at 0 -> no frame_valid.
REQ-037 Reset asserted at pass 4 -> outputs cleared immediately; the next frame reports correctly; no spurious frame_valid.
REQ-038 pass_in forced to 0 at pass 5 (early latch) -> partial frame discarded; only the restarted frame produces frame_valid.
